instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 59 +++++
 rtl/instr_sequencer.sv | 137 +++++++++++++
 tb/tb_instr_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Control/strobe bundle between the instruction sequencer and the datapath.
// Optional CycleCount signal present only when SEQ_CYCLE_CNT_EN is defined.
interface instr_sequencer_if;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 16;

  // Decoder / datapath status into the sequencer
  logic               Start;
  logic               IsHalt;
  logic               CtrlRegWrite;
  logic               CtrlMemWrite;
  logic               CtrlLdSt;
  logic               CtrlBranchRel;
  logic               BranchTaken;
  logic               MemReady;

  // Sequencer strobes and status
  logic               PCLoad;
  logic               PCInc;
  logic               PCBranch;
  logic               IRLoad;
  logic               RegWriteGate;
  logic               MemReq;
  logic               MemWriteGate;
  logic               Done;
  logic [STATE_W-1:0] State;
  logic [CNT_W-1:0]   InstrCount;
`ifdef SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0]   CycleCount;
`endif

`ifdef SEQ_CYCLE_CNT_EN
  modport master (
    output Start, IsHalt, CtrlRegWrite, CtrlMemWrite, CtrlLdSt,
           CtrlBranchRel, BranchTaken, MemReady,
    input  PCLoad, PCInc, PCBranch, IRLoad, RegWriteGate, MemReq,
           MemWriteGate, Done, State, InstrCount, CycleCount
  );
  modport slave (
    input  Start, IsHalt, CtrlRegWrite, CtrlMemWrite, CtrlLdSt,
           CtrlBranchRel, BranchTaken, MemReady,
    output PCLoad, PCInc, PCBranch, IRLoad, RegWriteGate, MemReq,
           MemWriteGate, Done, State, InstrCount, CycleCount
  );
`else
  modport master (
    output Start, IsHalt, CtrlRegWrite, CtrlMemWrite, CtrlLdSt,
           CtrlBranchRel, BranchTaken, MemReady,
    input  PCLoad, PCInc, PCBranch, IRLoad, RegWriteGate, MemReq,
           MemWriteGate, Done, State, InstrCount
  );
  modport slave (
    input  Start, IsHalt, CtrlRegWrite, CtrlMemWrite, CtrlLdSt,
           CtrlBranchRel, BranchTaken, MemReady,
    output PCLoad, PCInc, PCBranch, IRLoad, RegWriteGate, MemReq,
           MemWriteGate, Done, State, InstrCount
  );
`endif
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/EXEC/MEM/WB per instruction,
// gates PC, IR, register-file and data-memory strobes, counts retired
// instructions. Define SEQ_CYCLE_CNT_EN to add the busy-cycle counter.
module instr_sequencer (
  input  logic              Clk,
  input  logic              Reset_n,
  instr_sequencer_if.slave  bus
);
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 16;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_START = 3'd1;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd2;
  localparam logic [STATE_W-1:0] S_EXEC  = 3'd3;
  localparam logic [STATE_W-1:0] S_MEM   = 3'd4;
  localparam logic [STATE_W-1:0] S_WB    = 3'd5;
  localparam logic [STATE_W-1:0] S_HALT  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [CNT_W-1:0]   icnt_q;
  logic               pc_load;
  logic               pc_inc;
  logic               pc_branch;
  logic               ir_load;
  logic               rw_gate;
  logic               mem_req;
  logic               mw_gate;
  logic               done;
  logic               retire;
  logic               cnt_clear;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and strobe decode; strobes fall with state on async reset
  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    ir_load   = 1'b0;
    rw_gate   = 1'b0;
    mem_req   = 1'b0;
    mw_gate   = 1'b0;
    done      = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) state_d = S_START;
      end
      S_START: begin
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.IsHalt)                           state_d = S_HALT;
        else if (bus.CtrlMemWrite || bus.CtrlLdSt) state_d = S_MEM;
        else                                      state_d = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mw_gate = bus.CtrlMemWrite;
        if (bus.MemReady) begin
          if (bus.CtrlMemWrite) begin
            // store retires straight out of MEM
            pc_inc  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rw_gate = bus.CtrlRegWrite;
        if (bus.CtrlBranchRel && bus.BranchTaken) pc_branch = 1'b1;
        else                                      pc_inc    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (bus.Start) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters clear on the edge into START so they read zero during START
  assign cnt_clear = (state_d == S_START);

  // Retired-instruction counter, saturating
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                         icnt_q <= '0;
    else if (cnt_clear)                   icnt_q <= '0;
    else if (retire && icnt_q != CNT_MAX) icnt_q <= icnt_q + CNT_W'(1);
  end

`ifdef SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] ccnt_q;
  logic             busy;

  assign busy = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                (state_q == S_MEM)   || (state_q == S_WB);

  // Busy-cycle counter, saturating, held in IDLE/HALT
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                       ccnt_q <= '0;
    else if (cnt_clear)                 ccnt_q <= '0;
    else if (busy && ccnt_q != CNT_MAX) ccnt_q <= ccnt_q + CNT_W'(1);
  end

  assign bus.CycleCount = ccnt_q;
`endif

  assign bus.PCLoad       = pc_load;
  assign bus.PCInc        = pc_inc;
  assign bus.PCBranch     = pc_branch;
  assign bus.IRLoad       = ir_load;
  assign bus.RegWriteGate = rw_gate;
  assign bus.MemReq       = mem_req;
  assign bus.MemWriteGate = mw_gate;
  assign bus.Done         = done;
  assign bus.State        = state_q;
  assign bus.InstrCount   = icnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: instruction-level reference model
// expands each program into an expected per-cycle trace.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_HALT = 4;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcload, pcinc, pcbr, irload, rwg, mreq, mwg, done;
    logic [15:0] icnt;
    logic [15:0] cyc;
  } obs_t;

  typedef struct packed {
    logic start, ishalt, rw, mw, ld, br, taken, mready;
  } stim_t;

  typedef struct { stim_t s; obs_t e; } cyc_t;
  typedef struct { int kind; int nmem; bit taken; bit rw; } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_sequencer_if bus();
  instr_sequencer dut (.Clk(clk), .Reset_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int unsigned exp_icnt = 0;
  int unsigned exp_cyc  = 0;
  bit in_halt = 1'b0;
  instr_t prog[$];
  cyc_t   expq[$];
  obs_t   obsq[$];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void add(logic [2:0] st, stim_t s, logic pcload, logic pcinc,
                              logic pcbr, logic irload, logic rwg, logic mreq,
                              logic mwg, logic done, bit busy, bit ret);
    cyc_t c;
    c.s = s;
    c.e.st = st; c.e.pcload = pcload; c.e.pcinc = pcinc; c.e.pcbr = pcbr;
    c.e.irload = irload; c.e.rwg = rwg; c.e.mreq = mreq; c.e.mwg = mwg;
    c.e.done = done; c.e.icnt = 16'(exp_icnt);
`ifdef SEQ_CYCLE_CNT_EN
    c.e.cyc = 16'(exp_cyc);
`else
    c.e.cyc = 16'h0;
`endif
    expq.push_back(c);
    if (busy && exp_cyc < 65535) exp_cyc++;
    if (ret && exp_icnt < 65535) exp_icnt++;
  endfunction

  function automatic stim_t noisy(stim_t ctrl);
    stim_t s = ctrl;
    s.start  = 1'($urandom_range(0, 1));
    s.mready = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Expand prog[] into expq[], starting from IDLE or HALT with a Start pulse
  function automatic void gen();
    stim_t s;
    stim_t ctl;
    bit tk;
    expq.delete();
    s = '0; s.start = 1'b1; s.mready = 1'($urandom_range(0, 1));
    add(in_halt ? 3'd6 : 3'd0, s, 0,0,0,0,0,0,0, in_halt, 0, 0);
    exp_icnt = 0; exp_cyc = 0;
    add(3'd1, noisy('0), 1,0,0,0,0,0,0,0, 0, 0);
    foreach (prog[i]) begin
      ctl = '0;
      ctl.taken = 1'($urandom_range(0, 1));
      case (prog[i].kind)
        K_ALU:  ctl.rw = prog[i].rw;
        K_BR:   begin ctl.br = 1'b1; ctl.taken = prog[i].taken; end
        K_LD:   begin ctl.ld = 1'b1; ctl.rw = prog[i].rw; end
        K_ST:   begin ctl.mw = 1'b1; ctl.rw = 1'($urandom_range(0, 1)); end
        default: begin
          ctl.ishalt = 1'b1;
          ctl.rw = 1'($urandom_range(0, 1));
          ctl.mw = 1'($urandom_range(0, 1));
          ctl.ld = 1'($urandom_range(0, 1));
        end
      endcase
      add(3'd2, noisy(ctl), 0,0,0,1,0,0,0,0, 1, 0);
      add(3'd3, noisy(ctl), 0,0,0,0,0,0,0,0, 1, 0);
      tk = ctl.br & ctl.taken;
      case (prog[i].kind)
        K_ALU, K_BR: add(3'd5, noisy(ctl), 0, !tk, tk, 0, ctl.rw, 0,0,0, 1, 1);
        K_LD: begin
          for (int j = 0; j < prog[i].nmem; j++) begin
            s = noisy(ctl); s.mready = (j == prog[i].nmem - 1);
            add(3'd4, s, 0,0,0,0,0, 1, 0, 0, 1, 0);
          end
          add(3'd5, noisy(ctl), 0, 1, 0, 0, ctl.rw, 0,0,0, 1, 1);
        end
        K_ST: begin
          for (int j = 0; j < prog[i].nmem; j++) begin
            s = noisy(ctl); s.mready = (j == prog[i].nmem - 1);
            add(3'd4, s, 0, s.mready, 0, 0, 0, 1, 1, 0, 1, s.mready);
          end
        end
        default: begin
          s = noisy('0); s.start = 1'b0;
          add(3'd6, s, 0,0,0,0,0,0,0, 1, 0, 0);
        end
      endcase
    end
    in_halt = 1'b1;
  endfunction

  // ---------------- stimulus / sampling ----------------
  task automatic drive(input stim_t s);
    bus.Start = s.start; bus.IsHalt = s.ishalt; bus.CtrlRegWrite = s.rw;
    bus.CtrlMemWrite = s.mw; bus.CtrlLdSt = s.ld; bus.CtrlBranchRel = s.br;
    bus.BranchTaken = s.taken; bus.MemReady = s.mready;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.State; o.pcload = bus.PCLoad; o.pcinc = bus.PCInc;
    o.pcbr = bus.PCBranch; o.irload = bus.IRLoad; o.rwg = bus.RegWriteGate;
    o.mreq = bus.MemReq; o.mwg = bus.MemWriteGate; o.done = bus.Done;
    o.icnt = bus.InstrCount;
`ifdef SEQ_CYCLE_CNT_EN
    o.cyc = bus.CycleCount;
`else
    o.cyc = 16'h0;
`endif
    return o;
  endfunction

  task automatic play(input int limit);
    obsq.delete();
    foreach (expq[i]) begin
      if (limit >= 0 && i >= limit) break;
      @(negedge clk);
      drive(expq[i].s);
      #1;
      obsq.push_back(sample());
    end
  endtask

  function automatic instr_t mk(int kind, int nmem, bit taken, bit rw);
    instr_t x;
    x.kind = kind; x.nmem = nmem; x.taken = taken; x.rw = rw;
    return x;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    stim_t s;
    s = noisy('0); s.start = 1'b1; s.mready = 1'b1;
    drive(s);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (sample() !== obs_t'(0)) begin
      fails++; $display("FAIL reset_hold got %h exp 0", sample());
    end
    s.start = 1'b0;
    drive(s);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(noisy('0)); bus.Start = 1'b0; #1;
      tests++;
      if (sample() !== obs_t'(0)) begin
        fails++; $display("FAIL reset_idle cyc %0d got %h exp 0", i, sample());
      end
    end
    in_halt = 1'b0; exp_icnt = 0; exp_cyc = 0;
  endtask

  task automatic test_alu_program();
    logic [2:0] seq [10];
    int loads;
    seq = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd2, 3'd3, 3'd5, 3'd2, 3'd3, 3'd6};
    prog = '{mk(K_ALU, 0, 0, 1), mk(K_ALU, 0, 0, 1), mk(K_HALT, 0, 0, 0)};
    gen(); play(-1);
    foreach (obsq[i]) begin
      tests++;
      if (obsq[i] !== expq[i].e) begin
        fails++; $display("FAIL alu_trace cyc %0d got %h exp %h", i, obsq[i], expq[i].e);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (obsq[i+1].st !== seq[i]) begin
        fails++; $display("FAIL alu_state step %0d got %0d exp %0d", i, obsq[i+1].st, seq[i]);
      end
    end
    loads = 0;
    foreach (obsq[i]) if (obsq[i].pcload) loads++;
    tests++;
    if (loads != 1 || obsq[10].done !== 1'b1 || obsq[10].icnt !== 16'd2) begin
      fails++; $display("FAIL alu_end pcload %0d done %b icnt %0d exp 1/1/2",
                        loads, obsq[10].done, obsq[10].icnt);
    end
  endtask

  task automatic test_load_stall();
    int nmem, incs, mwgs;
    prog = '{mk(K_LD, 4, 0, 1), mk(K_HALT, 0, 0, 0)};
    gen(); play(-1);
    foreach (obsq[i]) begin
      tests++;
      if (obsq[i] !== expq[i].e) begin
        fails++; $display("FAIL load_trace cyc %0d got %h exp %h", i, obsq[i], expq[i].e);
      end
    end
    nmem = 0; incs = 0; mwgs = 0;
    foreach (obsq[i]) begin
      if (obsq[i].st == 3'd4) nmem++;
      if (obsq[i].pcinc) incs++;
      if (obsq[i].mwg) mwgs++;
    end
    tests++;
    if (nmem != 4 || incs != 1 || mwgs != 0 || obsq[8].st !== 3'd5 || obsq[8].rwg !== 1'b1) begin
      fails++; $display("FAIL load_stall mem %0d inc %0d mwg %0d wb_st %0d rwg %b exp 4/1/0/5/1",
                        nmem, incs, mwgs, obsq[8].st, obsq[8].rwg);
    end
  endtask

  task automatic test_store_fast();
    int wbs;
    prog = '{mk(K_ST, 1, 0, 0), mk(K_HALT, 0, 0, 0)};
    gen(); play(-1);
    foreach (obsq[i]) begin
      tests++;
      if (obsq[i] !== expq[i].e) begin
        fails++; $display("FAIL store_trace cyc %0d got %h exp %h", i, obsq[i], expq[i].e);
      end
    end
    wbs = 0;
    foreach (obsq[i]) if (obsq[i].st == 3'd5) wbs++;
    tests++;
    if (obsq[4].st !== 3'd4 || obsq[4].mwg !== 1'b1 || obsq[4].pcinc !== 1'b1 ||
        obsq[5].st !== 3'd2 || wbs != 0) begin
      fails++; $display("FAIL store_fast st %0d mwg %b inc %b next %0d wb %0d exp 4/1/1/2/0",
                        obsq[4].st, obsq[4].mwg, obsq[4].pcinc, obsq[5].st, wbs);
    end
  endtask

  task automatic test_branch();
    prog = '{mk(K_BR, 0, 1, 0), mk(K_BR, 0, 0, 0), mk(K_HALT, 0, 0, 0)};
    gen(); play(-1);
    foreach (obsq[i]) begin
      tests++;
      if (obsq[i] !== expq[i].e) begin
        fails++; $display("FAIL branch_trace cyc %0d got %h exp %h", i, obsq[i], expq[i].e);
      end
    end
    tests++;
    if ({obsq[4].pcbr, obsq[4].pcinc, obsq[4].rwg, obsq[7].pcbr, obsq[7].pcinc, obsq[7].rwg}
        !== 6'b100_010) begin
      fails++; $display("FAIL branch_strobes got %b%b%b_%b%b%b exp 100_010",
                        obsq[4].pcbr, obsq[4].pcinc, obsq[4].rwg,
                        obsq[7].pcbr, obsq[7].pcinc, obsq[7].rwg);
    end
  endtask

  task automatic test_restart();
    prog = '{mk(K_ALU, 0, 0, 1), mk(K_HALT, 0, 0, 0)};
    gen(); play(-1);
    foreach (obsq[i]) begin
      tests++;
      if (obsq[i] !== expq[i].e) begin
        fails++; $display("FAIL restart_trace cyc %0d got %h exp %h", i, obsq[i], expq[i].e);
      end
    end
    tests++;
    if (obsq[0].st !== 3'd6 || obsq[0].done !== 1'b1 || obsq[0].icnt !== 16'd2 ||
        obsq[1].st !== 3'd1 || obsq[1].pcload !== 1'b1 || obsq[1].icnt !== 16'd0) begin
      fails++; $display("FAIL restart st %0d done %b icnt %0d -> st %0d pcload %b icnt %0d exp 6/1/2 -> 1/1/0",
                        obsq[0].st, obsq[0].done, obsq[0].icnt,
                        obsq[1].st, obsq[1].pcload, obsq[1].icnt);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      prog.delete();
      for (int k = $urandom_range(3, 15); k > 0; k--)
        prog.push_back(mk($urandom_range(0, 3), $urandom_range(1, 5),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
      prog.push_back(mk(K_HALT, 0, 0, 0));
      gen(); play(-1);
      foreach (obsq[i]) begin
        tests++;
        if (obsq[i] !== expq[i].e) begin
          fails++; $display("FAIL random_trace prog %0d cyc %0d got %h exp %h",
                            p, i, obsq[i], expq[i].e);
        end
        tests++;
        if ((obsq[i].pcinc & obsq[i].pcbr) || (obsq[i].pcload & (obsq[i].pcinc | obsq[i].pcbr))) begin
          fails++; $display("FAIL pc_exclusive prog %0d cyc %0d load %b inc %b br %b exp one-hot",
                            p, i, obsq[i].pcload, obsq[i].pcinc, obsq[i].pcbr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    prog = '{mk(K_ALU, 0, 0, 1), mk(K_ST, 10, 0, 0), mk(K_HALT, 0, 0, 0)};
    gen(); play(9);
    tests++;
    if (obsq[8].st !== 3'd4 || obsq[8].mreq !== 1'b1 || obsq[8].mwg !== 1'b1 || obsq[8].icnt !== 16'd1) begin
      fails++; $display("FAIL midmem_pre st %0d mreq %b mwg %b icnt %0d exp 4/1/1/1",
                        obsq[8].st, obsq[8].mreq, obsq[8].mwg, obsq[8].icnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.MemReq !== 1'b0 || bus.MemWriteGate !== 1'b0 || bus.State !== 3'd0 || bus.InstrCount !== 16'd0) begin
      fails++; $display("FAIL midmem_reset mreq %b mwg %b st %0d icnt %0d exp 0/0/0/0",
                        bus.MemReq, bus.MemWriteGate, bus.State, bus.InstrCount);
    end
    @(negedge clk);
    bus.Start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.Start = 1'b0; bus.MemReady = 1'($urandom_range(0, 1)); #1;
      tests++;
      if (sample() !== obs_t'(0)) begin
        fails++; $display("FAIL midmem_noresume cyc %0d got %h exp 0", i, sample());
      end
    end
    in_halt = 1'b0; exp_icnt = 0; exp_cyc = 0;
    prog = '{mk(K_LD, 2, 0, 1), mk(K_HALT, 0, 0, 0)};
    gen(); play(-1);
    foreach (obsq[i]) begin
      tests++;
      if (obsq[i] !== expq[i].e) begin
        fails++; $display("FAIL post_reset_trace cyc %0d got %h exp %h", i, obsq[i], expq[i].e);
      end
    end
  endtask

`ifdef SEQ_CYCLE_CNT_EN
  task automatic test_cycle_count();
    prog = '{mk(K_LD, 70000, 0, 1), mk(K_HALT, 0, 0, 0)};
    gen(); play(-1);
    foreach (obsq[i]) begin
      if (i < 20 || i + 20 > obsq.size()) begin
        tests++;
        if (obsq[i] !== expq[i].e) begin
          fails++; $display("FAIL cycle_trace cyc %0d got %h exp %h", i, obsq[i], expq[i].e);
        end
      end
    end
    tests++;
    if (obsq[obsq.size()-1].cyc !== 16'hFFFF) begin
      fails++; $display("FAIL cycle_sat got %h exp ffff", obsq[obsq.size()-1].cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_program();
    test_load_stall();
    test_store_fast();
    test_branch();
    test_restart();
    test_random();
    test_reset_mid_mem();
`ifdef SEQ_CYCLE_CNT_EN
    test_cycle_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
